i2c_slave: RTL and testbench

- Oversampled I2C target (slave) sitting directly downstream of the team's I2C master, on the same sclk/sda pair.
- Samples sclk and sda_in on the system clock, detects START/STOP, and matches a 7-bit address.
- For master-write transfers it receives bytes and presents them on a parallel port.
- For master-read transfers it serialises bytes taken from a parallel port back to the master.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_line_sync.sv | 83 ++++++++
 rtl/i2c_slave.sv | 155 +++++++++++++++
 tb/tb_i2c_slave.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// State encoding, R/W constants, bus widths and a majority helper.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    TX       = 3'd3,
    TX_ACK   = 3'd4,
    RX       = 3'd5,
    RX_ACK   = 3'd6
  } state_t;

  function automatic logic maj3(input logic a,
                                input logic b,
                                input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises sclk/sda_in, optionally majority-filters them
// (I2C_SLAVE_GLITCH_FILTER_EN), and derives edge/START/STOP events.
// Ports: clk, rst (async, active-low), sclk, sda_in ->
//   sda_lvl, sclk_rise, sclk_fall, start, stop.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sda_in,
  output logic sda_lvl,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_q, sda_q;
  logic scl_h, sda_h;

  // Reset to 1: an idle bus, so no false events on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_d, sda_d;
  logic scl_f, sda_f;

  // Registered vote over three samples: 2 clk extra latency,
  // single-cycle pulses never win the vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_d <= '1;
      sda_d <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_d <= {scl_d[0], scl_sync[SYNC_STAGES-1]};
      sda_d <= {sda_d[0], sda_sync[SYNC_STAGES-1]};
      scl_f <= maj3(scl_sync[SYNC_STAGES-1],
                    scl_d[0], scl_d[1]);
      sda_f <= maj3(sda_sync[SYNC_STAGES-1],
                    sda_d[0], sda_d[1]);
    end
  end

  assign scl_q = scl_f;
  assign sda_q = sda_f;
`else
  assign scl_q = scl_sync[SYNC_STAGES-1];
  assign sda_q = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_h <= scl_q;
      sda_h <= sda_q;
    end
  end

  assign sda_lvl   = sda_q;
  assign sclk_rise = scl_q & ~scl_h;
  assign sclk_fall = ~scl_q & scl_h;
  // sclk must be high on both samples around the sda edge.
  assign start = scl_q & scl_h & sda_h & ~sda_q;
  assign stop  = scl_q & scl_h & ~sda_h & sda_q;

endmodule

// File: rtl/i2c_slave.sv
// Oversampled I2C target: address match, byte receive and transmit.
// Ports: clk, rst (async, active-low), sclk, sda_in, sda_out, tx_data,
//   tx_req, rx_data, rx_valid, addr_match, state. Option: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sda_in,
  output logic              sda_out,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              addr_match,
  output logic [2:0]        state
);

  logic sda, sclk_rise, sclk_fall, start, stop;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_lvl  (sda),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t            st;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] sh;
  logic              rw;
  logic              ack_on;
  logic              nack;

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      rw         <= WRITE;
      ack_on     <= 1'b0;
      nack       <= 1'b1;
      sda_out    <= 1'b1;
      tx_req     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (stop) begin
        st         <= IDLE;
        sda_out    <= 1'b1;
        addr_match <= 1'b0;
      end else if (start) begin
        st         <= ADDR;
        sda_out    <= 1'b1;
        addr_match <= 1'b0;
        cnt        <= '0;
      end else begin
        unique case (st)
          IDLE: sda_out <= 1'b1;
          ADDR: if (sclk_rise) begin
            sh  <= {sh[DATA_W-2:0], sda};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              rw     <= sda;
              ack_on <= 1'b0;
              st     <= (sh[ADDR_W-1:0] == SLAVE_ADDR)
                        ? ADDR_ACK : IDLE;
            end
          end
          ADDR_ACK: if (sclk_fall) begin
            if (!ack_on) begin
              sda_out    <= 1'b0;
              addr_match <= 1'b1;
              ack_on     <= 1'b1;
            end else if (rw == READ) begin
              sh      <= tx_data;
              tx_req  <= 1'b1;
              sda_out <= tx_data[DATA_W-1];
              cnt     <= 4'd1;
              st      <= TX;
            end else begin
              sda_out <= 1'b1;
              cnt     <= '0;
              st      <= RX;
            end
          end
          // cnt counts bits already placed on the bus.
          TX: if (sclk_fall) begin
            if (cnt == 4'd8) begin
              sda_out <= 1'b1;
              st      <= TX_ACK;
            end else begin
              sda_out <= sh[~cnt[2:0]];
              cnt     <= cnt + 4'd1;
            end
          end
          TX_ACK: begin
            if (sclk_rise) begin
              nack <= sda;
            end else if (sclk_fall) begin
              if (nack) begin
                sda_out <= 1'b1;
                st      <= IDLE;
              end else begin
                sh      <= tx_data;
                tx_req  <= 1'b1;
                sda_out <= tx_data[DATA_W-1];
                cnt     <= 4'd1;
                st      <= TX;
              end
            end
          end
          RX: if (sclk_rise) begin
            sh  <= {sh[DATA_W-2:0], sda};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              rx_data  <= {sh[DATA_W-2:0], sda};
              rx_valid <= 1'b1;
              ack_on   <= 1'b0;
              st       <= RX_ACK;
            end
          end
          RX_ACK: if (sclk_fall) begin
            if (!ack_on) begin
              sda_out <= 1'b0;
              ack_on  <= 1'b1;
            end else begin
              sda_out <= 1'b1;
              cnt     <= '0;
              st      <= RX;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master, transaction model,
// per-cycle compare process, directed and random transfers.
module tb_i2c_slave;

  localparam int HI = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sclk, sda_in, sda_out;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req, rx_valid, addr_match;
  logic [7:0] rx_data;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  bit nomatch = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_first[$];
  logic [7:0] tx_plan[$];
  logic [7:0] wr_plan[$];
  logic [7:0] rd_log[$];

  assign sclk   = m_scl;
  assign sda_in = m_sda & sda_out;

  always #5 clk = ~clk;

  i2c_slave #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sda_in    (sda_in),
    .sda_out   (sda_out),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .addr_match(addr_match),
    .state     (state)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Compare process: runs every cycle against the transaction model.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rxv_cnt++;
        if (exp_rx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_valid_extra: got rx_data=0x%0h expected no pulse",
                   rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      if (tx_req) begin
        txr_cnt++;
        exp_tx.push_back(tx_data);
        tx_data = (tx_plan.size() > 0) ? tx_plan.pop_front()
                                       : 8'($urandom);
      end else if (state == 3'd0 && tx_first.size() > 0) begin
        tx_data = tx_first.pop_front();
      end
      if (rst && state == 3'd0)
        check("idle_sda_release", sda_out, 1);
      if (nomatch) begin
        check("nomatch_sda", sda_out, 1);
        check("nomatch_addr_match", addr_match, 0);
      end
      check("state_legal", 32'(state <= 3'd6), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    if (!m_scl) begin
      m_sda = 1'b1;
      tick(6);
      m_scl = 1'b1;
      tick(HI);
    end
    m_sda = 1'b0;
    tick(HI);
    m_scl = 1'b0;
    tick(2);
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    tick(6);
    m_scl = 1'b1;
    tick(HI);
    m_sda = 1'b1;
    tick(HI);
  endtask

  // One bus clock; called 2 clk after sclk fell, returns likewise.
  task automatic clk_bit(input logic b, output logic r);
    m_sda = b;
    tick(6);
    m_scl = 1'b1;
    tick(HI / 2);
    r = sda_in;
    tick(HI / 2);
    m_scl = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    acked = !r;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      b[i] = r;
    end
    clk_bit(!ack, r);
  endtask

  task automatic xfer(input logic [6:0] a, input logic rd,
                      input int nbytes, input int abort_bits,
                      input logic with_stop);
    logic       ack, r, match;
    logic [7:0] b;
    match = (a == 7'h50);
    do_start();
    if (!match) nomatch = 1'b1;
    send_byte({a, rd}, ack);
    check("addr_ack", ack, match);
    check("addr_match", addr_match, match);
    if (!match) begin
      for (int k = 0; k < nbytes; k++) begin
        send_byte(8'($urandom), ack);
        check("nomatch_data_ack", ack, 0);
      end
    end else if (!rd) begin
      for (int k = 0; k < nbytes; k++) begin
        b = (wr_plan.size() > 0) ? wr_plan.pop_front()
                                 : 8'($urandom);
        exp_rx.push_back(b);
        send_byte(b, ack);
        check("data_ack", ack, 1);
      end
      for (int j = 0; j < abort_bits; j++)
        clk_bit(1'($urandom), r);
    end else begin
      for (int k = 0; k < nbytes; k++) begin
        recv_byte(b, k < nbytes - 1);
        rd_log.push_back(b);
        if (exp_tx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_byte: got 0x%0h expected a tx_req first", b);
        end else begin
          check("tx_byte", b, exp_tx.pop_front());
        end
      end
      tick(3);
      check("nack_idle", state, 0);
      check("nack_release", sda_out, 1);
    end
    if (with_stop) begin
      do_stop();
      tick(2);
      check("idle_after_stop", state, 0);
      check("match_cleared", addr_match, 0);
    end
    nomatch = 1'b0;
  endtask

  initial begin
    int v_rx, v_tx;
    logic r;
    logic [6:0] a;
    logic rd;
    int nb, ab;

    tick(3);
    check("rst_sda_out", sda_out, 1);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_state", state, 0);
    rst = 1'b1;
    tick(4);

    // Write 0xA5 to 0x50.
    v_rx = rxv_cnt;
    wr_plan.push_back(8'hA5);
    xfer(7'h50, 1'b0, 1, 0, 1'b1);
    check("wr_a5_rx_data", rx_data, 8'hA5);
    check("wr_a5_pulses", rxv_cnt - v_rx, 1);

    // Read 0xF6, master NACKs.
    v_tx = txr_cnt;
    rd_log.delete();
    tx_first.push_back(8'hF6);
    tick(3);
    xfer(7'h50, 1'b1, 1, 0, 1'b1);
    check("rd_f6_bits", rd_log[0], 8'hF6);
    check("rd_f6_txreq", txr_cnt - v_tx, 1);

    // Wrong address.
    v_rx = rxv_cnt;
    xfer(7'h51, 1'b0, 2, 0, 1'b1);
    check("nomatch_rx_valid", rxv_cnt - v_rx, 0);

    // Two-byte read 0x3C, 0xC3.
    v_tx = txr_cnt;
    rd_log.delete();
    tx_first.push_back(8'h3C);
    tx_plan.push_back(8'hC3);
    tick(3);
    xfer(7'h50, 1'b1, 2, 0, 1'b1);
    check("rd2_byte0", rd_log[0], 8'h3C);
    check("rd2_byte1", rd_log[1], 8'hC3);
    check("rd2_txreq", txr_cnt - v_tx, 2);

    // Partial byte cut by STOP, then a fresh write of 0x12.
    v_rx = rxv_cnt;
    xfer(7'h50, 1'b0, 0, 4, 1'b1);
    check("partial_no_rx_valid", rxv_cnt - v_rx, 0);
    wr_plan.push_back(8'h12);
    xfer(7'h50, 1'b0, 1, 0, 1'b1);
    check("after_partial_rx_data", rx_data, 8'h12);
    check("after_partial_pulses", rxv_cnt - v_rx, 1);

    // Reset in the middle of a transmitted byte.
    tx_first.push_back(8'h00);
    tick(3);
    do_start();
    send_byte({7'h50, 1'b1}, r);
    check("rst_tx_ack", r, 1);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    tick(2);
    check("pre_rst_state_tx", state, 3);
    check("pre_rst_sda_low", sda_out, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_sda", sda_out, 1);
    check("async_rst_state", state, 0);
    tick(2);
    m_scl = 1'b1;
    m_sda = 1'b1;
    exp_tx.delete();
    tick(3);
    rst = 1'b1;
    tick(4);
    v_rx = rxv_cnt;
    wr_plan.push_back(8'h5A);
    xfer(7'h50, 1'b0, 1, 0, 1'b1);
    check("post_rst_rx_data", rx_data, 8'h5A);
    check("post_rst_pulses", rxv_cnt - v_rx, 1);

    // Random traffic, mixed STOP and repeated START.
    for (int t = 0; t < 30; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      rd = 1'($urandom);
      nb = $urandom_range(1, 3);
      ab = (!rd && $urandom_range(0, 3) == 0)
           ? $urandom_range(1, 6) : 0;
      xfer(a, rd, nb, ab,
           (ab > 0) || ($urandom_range(0, 2) != 0));
    end
    if (m_scl == 1'b0) do_stop();
    tick(10);
    check("rx_all_seen", exp_rx.size(), 0);
    check("tx_all_read", exp_tx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
